// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// State encoding, step-counter sizing and the divide-by-zero quotient.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    ITER,
    FIX
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

  // Sliced down to WIDTH by the user; WIDTH is limited to 64.
  localparam logic [63:0] DBZ_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring shift-subtract iteration on {P,A} against B.
// Purely combinational; the top reuses it every ITER cycle.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   p_next,
  output logic [WIDTH-1:0] a_next
);

  logic [WIDTH+1:0] sh;
  logic [WIDTH+1:0] t;
  logic [WIDTH-1:0] a_sh;
  logic             ge;

  // Extra top bit turns the borrow into a sign we can test.
  assign sh   = {p, a[WIDTH-1]};
  assign t    = sh - {2'b00, b};
  assign ge   = ~t[WIDTH+1];
  assign a_sh = {a[WIDTH-2:0], 1'b0};

  assign p_next = ge ? t[WIDTH:0] : sh[WIDTH:0];
  assign a_next = {a_sh[WIDTH-1:1], ge};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider, signed or unsigned,
// with start/busy/done handshake and zero/overflow flags.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] DBZ_Q = DBZ_QUOT[WIDTH-1:0];

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH:0]   p;
  logic [CW-1:0]    cnt;
  logic             sgn_mode;
  logic             sgn_q;
  logic             sgn_r;
  logic             dbz;
  logic             ovf;

  logic [WIDTH:0]   p_n;
  logic [WIDTH-1:0] a_n;
  logic             sa;
  logic             sb;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p      (p),
    .a      (a),
    .b      (b),
    .p_next (p_n),
    .a_next (a_n)
  );

  assign sa   = sgn_mode & a[WIDTH-1];
  assign sb   = sgn_mode & b[WIDTH-1];
  assign busy = (state != IDLE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = PREP;
      PREP: state_n = (b == '0) ? FIX : ITER;
      ITER: if (cnt == '0) state_n = FIX;
      FIX:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a           <= '0;
      b           <= '0;
      dvd         <= '0;
      p           <= '0;
      cnt         <= '0;
      sgn_mode    <= 1'b0;
      sgn_q       <= 1'b0;
      sgn_r       <= 1'b0;
      dbz         <= 1'b0;
      ovf         <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a        <= dividend;
            b        <= divisor;
            dvd      <= dividend;
            sgn_mode <= is_signed & SIGNED_EN;
          end
        end
        PREP: begin
          sgn_q <= sa ^ sb;
          sgn_r <= sa;
          a     <= sa ? -a : a;
          b     <= sb ? -b : b;
          p     <= '0;
          cnt   <= CNT_LAST;
          dbz   <= (b == '0);
          ovf   <= sgn_mode && (a == MIN_VAL) && (b == '1);
        end
        ITER: begin
          p   <= p_n;
          a   <= a_n;
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          done        <= 1'b1;
          div_by_zero <= dbz;
          overflow    <= ovf & ~dbz;
          if (dbz) begin
            quotient  <= DBZ_Q;
            remainder <= dvd;
          end else begin
            quotient  <= sgn_q ? -a : a;
            remainder <= sgn_r ? -p[WIDTH-1:0]
                               : p[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=8): directed vectors
// queued at issue, checked by an independent done monitor.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  seq_divider #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
    int         at;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; start is sampled on the following posedge.
  task automatic issue(input string nm, input bit sg,
                       input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] q, input logic [7:0] r,
                       input bit dz, input bit ov, input int lat,
                       input bit push);
    exp_t e;
    start     = 1'b1;
    is_signed = sg;
    dividend  = x;
    divisor   = y;
    @(negedge clk);
    start     = 1'b0;
    is_signed = ~sg;
    dividend  = 8'($urandom);
    divisor   = 8'($urandom);
    if (push) begin
      e.name = nm;
      e.q    = q;
      e.r    = r;
      e.dz   = dz;
      e.ov   = ov;
      e.at   = cyc + lat;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               sb.size());
      sb.delete();
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL spurious_done: got done=1 expected 0");
        end else begin
          e = sb.pop_front();
          chk({e.name, "_q"},   32'(quotient),    32'(e.q));
          chk({e.name, "_r"},   32'(remainder),   32'(e.r));
          chk({e.name, "_dz"},  32'(div_by_zero), 32'(e.dz));
          chk({e.name, "_ov"},  32'(overflow),    32'(e.ov));
          chk({e.name, "_lat"}, 32'(cyc),         32'(e.at));
          chk({e.name, "_busy"}, 32'(busy),       32'd0);
        end
      end
    end
  end

  initial begin
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q",    32'(quotient), 32'd0);
    chk("rst_r",    32'(remainder), 32'd0);
    chk("rst_dz",   32'(div_by_zero), 32'd0);
    chk("rst_ov",   32'(overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue("u100_7", 0, 8'd100, 8'd7, 8'd14, 8'd2, 0, 0, 10, 1);
    chk("busy_after_start", 32'(busy), 32'd1);
    drain();
    issue("s_m7_2", 1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 0, 0, 10, 1);
    drain();
    issue("u55_0", 0, 8'd55, 8'd0, 8'hFF, 8'h37, 1, 0, 2, 1);
    drain();
    issue("s_ovf", 1, 8'h80, 8'hFF, 8'h80, 8'h00, 0, 1, 10, 1);
    drain();
    issue("u80_ff", 0, 8'h80, 8'hFF, 8'h00, 8'h80, 0, 0, 10, 1);
    drain();
    issue("s_7_m2", 1, 8'h07, 8'hFE, 8'hFD, 8'h01, 0, 0, 10, 1);
    drain();
    issue("s_dbz", 1, 8'hF0, 8'h00, 8'hFF, 8'hF0, 1, 0, 2, 1);
    drain();

    issue("mid_start", 0, 8'd200, 8'd9, 8'd22, 8'd2, 0, 0, 10, 1);
    repeat (3) @(negedge clk);
    start    = 1'b1;
    dividend = 8'd5;
    divisor  = 8'd1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_mid", 32'(busy), 32'd1);
    drain();
    repeat (14) @(negedge clk);

    issue("b2b_a", 0, 8'd250, 8'd10, 8'd25, 8'd0, 0, 0, 10, 1);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_seen", 32'(done), 32'd1);
    issue("b2b_b", 0, 8'd77, 8'd5, 8'd15, 8'd2, 0, 0, 10, 1);
    drain();

    issue("aborted", 0, 8'd200, 8'd3, 8'd0, 8'd0, 0, 0, 10, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_q",    32'(quotient), 32'd0);
    chk("abort_r",    32'(remainder), 32'd0);
    chk("abort_dz",   32'(div_by_zero), 32'd0);
    chk("abort_ov",   32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (14) @(negedge clk);
    issue("u255_16", 0, 8'd255, 8'd16, 8'd15, 8'd15, 0, 0, 10, 1);
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
